// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: memory-side responder for a 6-bit-address / 8-bit-data CPU port.
// Holds a 64x8 unified store. A loader FSM (IDLE -> LOAD -> FLUSH) streams a byte
// image into the store over a valid/ready port and holds the CPU while it does so.
// Optional feature macro: LOAD_CHECKSUM_EN builds the mod-256 running sum on ld_sum;
// without it ld_sum is tied to zero and no adder exists.
module cpu_mem_responder #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              memWr,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count,
    output logic [DATA_W-1:0] ld_sum
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Saturation value of the byte counter (== depth) and the last store index.
    localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_count;
    logic                w_ld_ready;
    logic                w_cpu_hold;
    logic                w_ld_done;
    logic                w_cpu_wr;
    logic                w_ld_xfer;
    logic                w_start_load;

    // Loader state register; reset returns to IDLE immediately, even mid-load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state strobes; CPU writes are only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_ld_ready   = 1'b0;
        w_cpu_hold   = 1'b0;
        w_ld_done    = 1'b0;
        w_cpu_wr     = 1'b0;
        w_ld_xfer    = 1'b0;
        w_start_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A write coinciding with ld_start still completes on this edge.
                w_cpu_wr     = memWr;
                w_start_load = ld_start;
                if (ld_start) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_ld_ready = 1'b1;
                w_cpu_hold = 1'b1;
                w_ld_xfer  = ld_valid;
                if (ld_valid && (r_ptr == PTR_LAST)) begin
                    w_next_state = ST_FLUSH;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                w_cpu_hold   = 1'b1;
                w_ld_done    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Store write port; contents are deliberately not reset so an image survives reset.
    always_ff @(posedge clk) begin
        if (w_ld_xfer) begin
            r_mem[r_ptr] <= ld_data;
        end else if (w_cpu_wr) begin
            r_mem[address] <= writedata;
        end
    end

    // Load pointer and saturating accepted-byte counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr   <= {ADDR_W{1'b0}};
            r_count <= {(ADDR_W+1){1'b0}};
        end else if (w_start_load) begin
            r_ptr   <= {ADDR_W{1'b0}};
            r_count <= {(ADDR_W+1){1'b0}};
        end else if (w_ld_xfer) begin
            r_ptr <= r_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (r_count < CNT_MAX) begin
                r_count <= r_count + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;

    // Mod-256 running sum of loaded bytes; held after the load until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum <= {DATA_W{1'b0}};
        end else if (w_start_load) begin
            r_sum <= {DATA_W{1'b0}};
        end else if (w_ld_xfer) begin
            r_sum <= r_sum + ld_data;
        end
    end

    assign ld_sum = r_sum;
`else
    assign ld_sum = {DATA_W{1'b0}};
`endif

    // Status outputs decode straight from the state flop; readdata is blanked under hold.
    assign ld_ready = w_ld_ready;
    assign cpu_hold = w_cpu_hold;
    assign ld_done  = w_ld_done;
    assign ld_count = r_count;
    assign readdata = w_cpu_hold ? {DATA_W{1'b0}} : r_mem[address];

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: randomized CPU and loader traffic checked
// every cycle against a transaction-level model (array store + load progress counters).
module tb_cpu_mem_responder;

    logic       clk;
    logic       reset;
    logic [5:0] address;
    logic       memWr;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       cpu_hold;
    logic       ld_done;
    logic [6:0] ld_count;
    logic [7:0] ld_sum;

    cpu_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .memWr     (memWr),
        .writedata (writedata),
        .readdata  (readdata),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .cpu_hold  (cpu_hold),
        .ld_done   (ld_done),
        .ld_count  (ld_count),
        .ld_sum    (ld_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: store image plus load progress expressed as bytes accepted.
    logic [7:0] m_mem [64];
    int         m_cnt;
    logic [7:0] m_sum;
    bit         m_loading;
    bit         m_flush;

    int n_checks;
    int n_pass;
    int n_done_seen;
    int n_ready_seen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_sum(input logic [7:0] s);
`ifdef LOAD_CHECKSUM_EN
        return s;
`else
        return 8'h00;
`endif
    endfunction

    // One clock cycle: drive inputs, check all outputs against the model, advance the model.
    task automatic cycle(input logic wr, input logic [5:0] a, input logic [7:0] wd,
                         input logic st, input logic v, input logic [7:0] d);
        bit hold_e;
        memWr = wr; address = a; writedata = wd; ld_start = st; ld_valid = v; ld_data = d;
        #3;
        hold_e = m_loading || m_flush;
        check_eq("cpu_hold", {31'd0, cpu_hold}, {31'd0, hold_e});
        check_eq("ld_ready", {31'd0, ld_ready}, {31'd0, m_loading});
        check_eq("ld_done",  {31'd0, ld_done},  {31'd0, m_flush});
        check_eq("ld_count", {25'd0, ld_count}, m_cnt);
        check_eq("ld_sum",   {24'd0, ld_sum},   {24'd0, exp_sum(m_sum)});
        check_eq("readdata", {24'd0, readdata}, hold_e ? 32'd0 : {24'd0, m_mem[a]});
        if (ld_done)  n_done_seen++;
        if (ld_ready) n_ready_seen++;
        // Effects of the coming rising edge.
        if (m_flush) begin
            m_flush = 1'b0;
        end else if (m_loading) begin
            if (v) begin
                m_mem[m_cnt] = d;
                m_sum = m_sum + d;
                m_cnt++;
                if (m_cnt == 64) begin
                    m_loading = 1'b0;
                    m_flush = 1'b1;
                end
            end
        end else begin
            if (wr) m_mem[a] = wd;
            if (st) begin
                m_loading = 1'b1;
                m_cnt = 0;
                m_sum = 8'h00;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse applied between clock edges, with immediate output checks.
    task automatic reset_pulse(input string tag);
        reset = 1'b0; memWr = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
        #2;
        check_eq({tag, "_hold"},  {31'd0, cpu_hold}, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, ld_ready}, 32'd0);
        check_eq({tag, "_done"},  {31'd0, ld_done},  32'd0);
        check_eq({tag, "_count"}, {25'd0, ld_count}, 32'd0);
        check_eq({tag, "_sum"},   {24'd0, ld_sum},   32'd0);
        m_loading = 1'b0; m_flush = 1'b0; m_cnt = 0; m_sum = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        m_loading = 1'b0; m_flush = 1'b0; m_cnt = 0; m_sum = 8'h00;
        reset = 1'b0; address = 6'd0; memWr = 1'b0; writedata = 8'h00;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset_pulse("rst0");

        // Give every store location a known value through the CPU port.
        for (int i = 0; i < 64; i++) cycle(1'b1, 6'(i), 8'($urandom), 1'b0, 1'b0, 8'h00);

        // Contents survive reset.
        cycle(1'b1, 6'd5, 8'h3C, 1'b0, 1'b0, 8'h00);
        address = 6'd5;
        reset_pulse("rst1");
        address = 6'd5;
        #1;
        check_eq("rst1_keep", {24'd0, readdata}, 32'h3C);

        // Single write, visible from the next cycle.
        cycle(1'b1, 6'h2A, 8'hA5, 1'b0, 1'b0, 8'h00);
        memWr = 1'b0;
        #1;
        check_eq("wr_2A", {24'd0, readdata}, 32'hA5);

        // Random CPU traffic in IDLE.
        for (int i = 0; i < 40; i++)
            cycle(1'($urandom), 6'($urandom), 8'($urandom), 1'b0, 1'b0, 8'h00);

        // Full load of 0..63 with ld_valid held; start coincides with a CPU write.
        n_done_seen = 0;
        cycle(1'b1, 6'h3F, 8'h99, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 64; i++) cycle(1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 8'(i));
        cycle(1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 8'h00);
        check_eq("seq_count", {25'd0, ld_count}, 32'd64);
        check_eq("seq_sum", {24'd0, ld_sum}, {24'd0, exp_sum(8'hE0)});
        check_eq("seq_dones", n_done_seen, 32'd1);
        for (int i = 0; i < 64; i++) cycle(1'b0, 6'(i), 8'h00, 1'b0, 1'b0, 8'h00);

        // Toggling ld_valid with CPU writes to 0x10 attempted throughout the load.
        n_done_seen = 0;
        n_ready_seen = 0;
        cycle(1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 128; k++)
            cycle(1'b1, 6'h10, 8'h77, 1'b0, (k % 2) == 0, 8'($urandom));
        check_eq("tog_ready_cycles", n_ready_seen, 32'd127);
        check_eq("tog_dones", n_done_seen, 32'd1);
        check_eq("tog_count", {25'd0, ld_count}, 32'd64);
        cycle(1'b0, 6'h10, 8'h00, 1'b0, 1'b0, 8'h00);

        // Random load with stalls, stray ld_start pulses and ignored CPU writes.
        n_done_seen = 0;
        cycle(1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 2000 && (m_loading || m_flush); c++)
            cycle(1'($urandom), 6'($urandom), 8'($urandom),
                  ($urandom_range(7, 0) == 0), 1'($urandom), 8'($urandom));
        check_eq("rnd_dones", n_done_seen, 32'd1);
        for (int i = 0; i < 64; i++) cycle(1'b0, 6'(i), 8'h00, 1'b0, 1'b0, 8'h00);

        // Reset after 20 bytes of a load.
        cycle(1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) cycle(1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 8'($urandom));
        check_eq("mid_count_pre", {25'd0, ld_count}, 32'd20);
        reset_pulse("rst_mid");
        for (int i = 0; i < 24; i++) cycle(1'b0, 6'(i), 8'h00, 1'b0, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
